// File: rtl/nq_apb_pkg.sv
// Shared types and default widths for the NanoQuarter APB requester bridge.
package nq_apb_pkg;

    localparam int NQ_APB_ADDR_W = 6;
    localparam int NQ_APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } nq_apb_state_e;

endpackage

// File: rtl/nq_apb_timeout.sv
// ACCESS wait-cycle counter; flags expiry on the wait cycle that brings the count to TIMEOUT.
module nq_apb_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is reported on the increment that reaches TIMEOUT, so the bridge
    // leaves ACCESS after exactly TIMEOUT unanswered wait cycles.
    assign expired = inc && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/nq_apb_master.sv
// APB requester bridge for the stage-2 load/store path.
// Optional ACCESS timeout is built when NQ_APB_TIMEOUT_EN is defined.
//
//   state  | meaning
//   IDLE   | req_ready high, bus quiet, waiting for a request
//   SETUP  | psel high, penable low, address/data from captured request
//   ACCESS | psel and penable high, waiting on pready (or timeout)
module nq_apb_master
    import nq_apb_pkg::*;
#(
    parameter int ADDR_W  = NQ_APB_ADDR_W,
    parameter int DATA_W  = NQ_APB_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    nq_apb_state_e     r_state;
    nq_apb_state_e     w_state_nxt;
    logic              w_done;
    logic              w_timed_out;
    logic              w_expired;
    logic              w_accept;

    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("nq_apb_master: TIMEOUT must be at least 1");
    end

`ifdef NQ_APB_TIMEOUT_EN
    nq_apb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state == SETUP),
        .inc     ((r_state == ACCESS) && !pready),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && req_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_timed_out = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                // A real responder answer wins over a coincident timeout.
                if (pready) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                    w_timed_out = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_done;
            if (w_accept) begin
                r_paddr  <= req_addr;
                r_pwrite <= req_write;
                r_pwdata <= req_wdata;
            end
            if (w_done) begin
                r_rsp_err <= w_timed_out | pslverr;
                if (!w_timed_out && !r_pwrite) begin
                    r_rsp_rdata <= prdata;
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign psel      = (r_state != IDLE);
    assign penable   = (r_state == ACCESS);
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
